// File: rtl/shared_register_arbiter_pkg.sv
// Shared helpers for the shared_register_arbiter slice.
// Holds the constant clog2 function used to cross-check the index width
// against the requester count when the design is elaborated.
package shared_register_arbiter_pkg;

  // Number of bits needed to encode 'value' distinct indices (minimum 0).
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int probe = 1; probe < value; probe = probe * 2) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/shared_register_arbiter_arbiter_round_robin.sv
// Combinational round-robin arbiter.
// Given the request vector and the one-hot previous grant, returns a one-hot
// grant for the first requester strictly after the previous winner, wrapping
// back to index 0. An all-zero last_grant degrades to plain priority from 0.
module arbiter_round_robin
  import shared_register_arbiter_pkg::*;
#(
  parameter int REQ_COUNT = 4
) (
  input  logic [REQ_COUNT-1:0] request,
  input  logic [REQ_COUNT-1:0] last_grant,
  output logic [REQ_COUNT-1:0] grant
);

  logic [REQ_COUNT-1:0]   upper_mask;
  logic [2*REQ_COUNT-1:0] scan_vec;
  logic [2*REQ_COUNT-1:0] scan_hit;
  logic                   found;

  // Mark every position strictly above the previous winner as eligible first.
  always_comb begin
    upper_mask    = '0;
    upper_mask[0] = 1'b0;
    for (int i = 1; i < REQ_COUNT; i++) begin
      upper_mask[i] = upper_mask[i-1] | last_grant[i-1];
    end
  end

  // Lower half holds the masked requests, upper half the full set, so a
  // simple low-to-high priority scan implements the wrap-around.
  assign scan_vec = {request, request & upper_mask};

  // Priority scan: keep only the lowest set bit of the double-width vector.
  always_comb begin
    scan_hit = '0;
    found    = 1'b0;
    for (int i = 0; i < 2*REQ_COUNT; i++) begin
      if (!found && scan_vec[i]) begin
        scan_hit[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Fold both halves back onto requester positions; at most one bit is set.
  assign grant = scan_hit[REQ_COUNT-1:0] | scan_hit[2*REQ_COUNT-1:REQ_COUNT];

endmodule

// File: rtl/shared_register_arbiter.sv
// Shared output register fed by INPUT_COUNT requesters.
// Round-robin picks one valid requester per cycle whenever the register is
// empty or being drained, captures its word and source index, and presents
// them downstream with a valid/ready handshake at up to one word per cycle.
module shared_register_arbiter
  import shared_register_arbiter_pkg::*;
#(
  parameter int                    INPUT_COUNT = 4,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    INDEX_WIDTH = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                              clock,
  input  logic                              clear_n,
  input  logic [INPUT_COUNT-1:0]            input_valid,
  output logic [INPUT_COUNT-1:0]            input_ready,
  input  logic [INPUT_COUNT*WORD_WIDTH-1:0] input_data,
  output logic                              output_valid,
  input  logic                              output_ready,
  output logic [WORD_WIDTH-1:0]             output_data,
  output logic [INDEX_WIDTH-1:0]            output_index
);

  // Refuse to elaborate with an inconsistent index width or too few requesters.
  generate
    if (INPUT_COUNT < 2 || INDEX_WIDTH != clog2(INPUT_COUNT)) begin : g_param_check
      $error("shared_register_arbiter: INDEX_WIDTH must equal clog2(INPUT_COUNT) and INPUT_COUNT >= 2");
    end
  endgenerate

  // Pointer reset value: last winner is the top requester, so 0 goes first.
  localparam logic [INPUT_COUNT-1:0] LAST_RESET = {1'b1, {(INPUT_COUNT-1){1'b0}}};

  logic                   output_valid_q, output_valid_d;
  logic [WORD_WIDTH-1:0]  output_data_q,  output_data_d;
  logic [INDEX_WIDTH-1:0] output_index_q, output_index_d;
  logic [INPUT_COUNT-1:0] last_q,         last_d;

  logic                   load_enable;
  logic                   handshake;
  logic [INPUT_COUNT-1:0] grant;
  logic [INDEX_WIDTH-1:0] grant_index;
  logic [WORD_WIDTH-1:0]  grant_word;

  arbiter_round_robin #(
    .REQ_COUNT (INPUT_COUNT)
  ) u_arbiter (
    .request    (input_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Register can accept a new word when empty or being emptied this cycle.
  assign load_enable = clear_n & (~output_valid_q | output_ready);
  assign input_ready = grant & {INPUT_COUNT{load_enable}};
  assign handshake   = |input_ready;

  // Encode the one-hot grant to a binary index and select the granted word.
  always_comb begin
    grant_index = '0;
    grant_word  = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      if (grant[i]) begin
        grant_index = grant_index | INDEX_WIDTH'(i);
        grant_word  = grant_word | input_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Next state: load on handshake, otherwise drop valid when drained.
  always_comb begin
    output_valid_d = output_valid_q;
    output_data_d  = output_data_q;
    output_index_d = output_index_q;
    last_d         = last_q;
    if (handshake) begin
      output_valid_d = 1'b1;
      output_data_d  = grant_word;
      output_index_d = grant_index;
      last_d         = grant;
    end else if (output_valid_q && output_ready) begin
      output_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      output_valid_q <= 1'b0;
      output_data_q  <= RESET_VALUE;
      output_index_q <= '0;
      last_q         <= LAST_RESET;
    end else begin
      output_valid_q <= output_valid_d;
      output_data_q  <= output_data_d;
      output_index_q <= output_index_d;
      last_q         <= last_d;
    end
  end

  assign output_valid = output_valid_q;
  assign output_data  = output_data_q;
  assign output_index = output_index_q;

endmodule
